// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, req/ack data-memory
// access FSM and MEM/WB register. StallM freezes upstream stages while memory is busy.
module memory_stage #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWriteE,
  input  logic          MemWriteE,
  input  logic [1:0]    MemtoRegE,
  input  logic          jumpE,
  input  logic [4:0]    WriteRegE,
  input  logic [DW-1:0] ALUMultOutE,
  input  logic [DW-1:0] WriteDataE,
  input  logic [DW-1:0] PCPlus4E,
  output logic [DW-1:0] ALUOutM,
  output logic [4:0]    WriteRegM,
  output logic          RegWriteM,
  output logic          StallM,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          misalignedM,
  output logic          RegWriteW,
  output logic [1:0]    MemtoRegW,
  output logic          jumpW,
  output logic [4:0]    WriteRegW,
  output logic [DW-1:0] ReadDataW,
  output logic [DW-1:0] ALUOutW,
  output logic [DW-1:0] PCPlus4W
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, stateNext;
  logic            MemWriteM;
  logic [1:0]      MemtoRegM;
  logic            jumpM;
  logic [DW-1:0]   WriteDataM;
  logic [DW-1:0]   PCPlus4M;
  logic            memop;

  assign memop      = MemWriteM | (MemtoRegM == 2'b01);
  assign StallM     = memop & ~dmem_ack;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUOutM[AW-1:0];
  assign dmem_wdata = WriteDataM;
  assign misalignedM = dmem_req & (dmem_addr[1:0] != 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    dmem_req  = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = memop;
        if (memop && !dmem_ack) stateNext = WAIT;
      end
      WAIT: begin
        // EX/MEM is frozen here, so the request fields stay stable.
        dmem_req = 1'b1;
        if (dmem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // EX/MEM register: holds while the memory access is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 2'b00;
      jumpM      <= 1'b0;
      WriteRegM  <= 5'd0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      MemtoRegM  <= MemtoRegE;
      jumpM      <= jumpE;
      WriteRegM  <= WriteRegE;
      ALUOutM    <= ALUMultOutE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
    end
  end

  // MEM/WB register: control fields become a bubble while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 2'b00;
      jumpW     <= 1'b0;
      WriteRegW <= 5'd0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      PCPlus4W  <= '0;
    end else begin
      RegWriteW <= RegWriteM & ~StallM;
      MemtoRegW <= StallM ? 2'b00 : MemtoRegM;
      jumpW     <= jumpM & ~StallM;
      WriteRegW <= WriteRegM;
      ReadDataW <= (memop && dmem_ack) ? dmem_rdata : '0;
      ALUOutW   <= ALUOutM;
      PCPlus4W  <= PCPlus4M;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU/jal pass-through, loads, stalled store,
// reset during a pending access, and back-to-back loads.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, jumpE;
  logic [1:0]  MemtoRegE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;
  logic [31:0] ALUOutM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, StallM, dmem_req, dmem_we, dmem_ack, misalignedM;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        RegWriteW, jumpW;
  logic [1:0]  MemtoRegW;
  logic [4:0]  WriteRegW;
  logic [31:0] ReadDataW, ALUOutW, PCPlus4W;

  int checks   = 0;
  int failures = 0;
  int reqCount = 0;
  int reqSnap;
  int stallCycles;

  memory_stage #(.DW(32), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .jumpE(jumpE), .WriteRegE(WriteRegE), .ALUMultOutE(ALUMultOutE),
    .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .misalignedM(misalignedM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .jumpW(jumpW),
    .WriteRegW(WriteRegW), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .PCPlus4W(PCPlus4W)
  );

  always #5 clk = ~clk;

  // Completed memory transactions, used to spot duplicate requests.
  always @(posedge clk) if (dmem_req && dmem_ack) reqCount <= reqCount + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic rw, input logic mw, input logic [1:0] m2r,
                         input logic jmp, input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4);
    RegWriteE = rw; MemWriteE = mw; MemtoRegE = m2r; jumpE = jmp;
    WriteRegE = wr; ALUMultOutE = alu; WriteDataE = wd; PCPlus4E = pc4;
  endtask

  task automatic bubble_e();
    drive_e(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ALUOutM"},   ALUOutM, 32'd0);
    check({tag, ".RegWriteM"}, {31'd0, RegWriteM}, 32'd0);
    check({tag, ".StallM"},    {31'd0, StallM}, 32'd0);
    check({tag, ".dmem_req"},  {31'd0, dmem_req}, 32'd0);
    check({tag, ".RegWriteW"}, {31'd0, RegWriteW}, 32'd0);
    check({tag, ".MemtoRegW"}, {30'd0, MemtoRegW}, 32'd0);
    check({tag, ".ReadDataW"}, ReadDataW, 32'd0);
    check({tag, ".ALUOutW"},   ALUOutW, 32'd0);
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive_e(1'b1, 1'b0, 2'b00, 1'b0, 5'd3, 32'h55, 32'h66, 32'h77);
    tick(); tick();
    check_all_zero("reset");
    #2 rst = 1'b0;
    bubble_e();
    tick();

    // ALU op passes E -> M -> W.
    drive_e(1'b1, 1'b0, 2'b00, 1'b0, 5'd5, 32'h10, 32'h0, 32'h0);
    tick();
    bubble_e();
    check("alu.ALUOutM",   ALUOutM, 32'h10);
    check("alu.WriteRegM", {27'd0, WriteRegM}, 32'd5);
    check("alu.RegWriteM", {31'd0, RegWriteM}, 32'd1);
    check("alu.req",       {31'd0, dmem_req}, 32'd0);
    tick();
    check("alu.ALUOutW",   ALUOutW, 32'h10);
    check("alu.RegWriteW", {31'd0, RegWriteW}, 32'd1);
    check("alu.WriteRegW", {27'd0, WriteRegW}, 32'd5);

    // Jump-and-link carries the link value through.
    drive_e(1'b1, 1'b0, 2'b00, 1'b1, 5'd31, 32'h0, 32'h0, 32'h100);
    tick(); bubble_e(); tick();
    check("jal.jumpW",    {31'd0, jumpW}, 32'd1);
    check("jal.PCPlus4W", PCPlus4W, 32'h100);

    // Load acked in the same cycle: no stall.
    drive_e(1'b1, 1'b0, 2'b01, 1'b0, 5'd8, 32'h40, 32'h0, 32'h0);
    tick();
    bubble_e();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    check("ld0.req",   {31'd0, dmem_req}, 32'd1);
    check("ld0.we",    {31'd0, dmem_we}, 32'd0);
    check("ld0.addr",  dmem_addr, 32'h40);
    check("ld0.stall", {31'd0, StallM}, 32'd0);
    check("ld0.mis",   {31'd0, misalignedM}, 32'd0);
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    check("ld0.ReadDataW", ReadDataW, 32'hDEADBEEF);
    check("ld0.MemtoRegW", {30'd0, MemtoRegW}, 32'd1);
    check("ld0.RegWriteW", {31'd0, RegWriteW}, 32'd1);
    check("ld0.WriteRegW", {27'd0, WriteRegW}, 32'd8);
    check("ld0.req_after", {31'd0, dmem_req}, 32'd0);

    // Store acked after 3 wait cycles; W sees bubbles meanwhile.
    drive_e(1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 32'h44, 32'h1234, 32'h0);
    tick();
    bubble_e();
    stallCycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (StallM) stallCycles++;
      check("st.req",   {31'd0, dmem_req}, 32'd1);
      check("st.we",    {31'd0, dmem_we}, 32'd1);
      check("st.addr",  dmem_addr, 32'h44);
      check("st.wdata", dmem_wdata, 32'h1234);
      tick();
      check("st.bubbleRegWriteW", {31'd0, RegWriteW}, 32'd0);
      check("st.bubbleMemtoRegW", {30'd0, MemtoRegW}, 32'd0);
    end
    check("st.stallCycles", stallCycles, 32'd3);
    dmem_ack = 1'b1;
    #1;
    check("st.ackStall", {31'd0, StallM}, 32'd0);
    check("st.ackAddr",  dmem_addr, 32'h44);
    tick();
    dmem_ack = 1'b0;
    check("st.RegWriteW", {31'd0, RegWriteW}, 32'd0);
    check("st.noReissue", {31'd0, dmem_req}, 32'd0);
    check("st.stallDone", {31'd0, StallM}, 32'd0);

    // Reset while a load waits: request drops at once, nothing written back.
    drive_e(1'b1, 1'b0, 2'b01, 1'b0, 5'd12, 32'h48, 32'h0, 32'h0);
    tick();
    bubble_e();
    tick();
    check("rstw.stall", {31'd0, StallM}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rstw");
    #2 rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    check("rstw.RegWriteW", {31'd0, RegWriteW}, 32'd0);
    check("rstw.ReadDataW", ReadDataW, 32'd0);

    // Misaligned load is still performed with the raw address.
    drive_e(1'b1, 1'b0, 2'b01, 1'b0, 5'd4, 32'h42, 32'h0, 32'h0);
    tick();
    bubble_e();
    dmem_ack = 1'b1; dmem_rdata = 32'h0000ABCD;
    #1;
    check("mis.flag", {31'd0, misalignedM}, 32'd1);
    check("mis.addr", dmem_addr, 32'h42);
    tick();
    dmem_ack = 1'b0;
    check("mis.ReadDataW", ReadDataW, 32'h0000ABCD);

    // Back-to-back loads, each acked in one cycle.
    reqSnap = reqCount;
    drive_e(1'b1, 1'b0, 2'b01, 1'b0, 5'd9, 32'h80, 32'h0, 32'h0);
    tick();
    drive_e(1'b1, 1'b0, 2'b01, 1'b0, 5'd10, 32'h84, 32'h0, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hA1A1A1A1;
    #1;
    check("b2b.addr0", dmem_addr, 32'h80);
    tick();
    bubble_e();
    dmem_rdata = 32'hA2A2A2A2;
    #1;
    check("b2b.addr1",      dmem_addr, 32'h84);
    check("b2b.ReadDataW0", ReadDataW, 32'hA1A1A1A1);
    check("b2b.WriteRegW0", {27'd0, WriteRegW}, 32'd9);
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    check("b2b.ReadDataW1", ReadDataW, 32'hA2A2A2A2);
    check("b2b.WriteRegW1", {27'd0, WriteRegW}, 32'd10);
    check("b2b.reqIdle",    {31'd0, dmem_req}, 32'd0);
    tick();
    check("b2b.requests",   reqCount - reqSnap, 32'd2);
    check("b2b.noDupW",     {31'd0, RegWriteW}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
